// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the Bluetooth message path:
//   - uart_state_t : transmitter FSM states (PARITY is used only when the
//                    UART_TX_PARITY_EN build macro is defined)
//   - CHAR_*       : ASCII codes the message formatter emits
//   - DEFAULT_CLKS_PER_BIT : 50 MHz / 115200 baud, truncated
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam logic [7:0] CHAR_F    = 8'h46;
    localparam logic [7:0] CHAR_I    = 8'h49;
    localparam logic [7:0] CHAR_M    = 8'h4D;
    localparam logic [7:0] CHAR_C    = 8'h43;
    localparam logic [7:0] CHAR_S    = 8'h53;
    localparam logic [7:0] CHAR_U    = 8'h55;
    localparam logic [7:0] CHAR_E    = 8'h45;
    localparam logic [7:0] CHAR_R    = 8'h52;
    localparam logic [7:0] CHAR_DASH = 8'h2D;
    localparam logic [7:0] CHAR_HASH = 8'h23;
    localparam logic [7:0] CHAR_0    = 8'h30;
    localparam logic [7:0] CHAR_1    = 8'h31;
    localparam logic [7:0] CHAR_2    = 8'h32;
    localparam logic [7:0] CHAR_3    = 8'h33;

endpackage

// File: rtl/uart_byte_tx_fifo.sv
// byte_fifo
// Small synchronous FIFO holding bytes waiting for the UART serialiser.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (control only)
//   push, push_data   : write request and data; ignored while full
//   pop, pop_data     : read request; pop_data shows the head combinationally
//   full, empty       : derived from the registered occupancy counter
//   count             : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; pointers already make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx
// Byte-wide front end for the HC-05 rxd line: bytes handed over on a
// valid/ready handshake are queued in byte_fifo and sent as UART frames,
// LSB first (8N1; 8E1 when UART_TX_PARITY_EN is defined).
// Ports:
//   clk        : system clock (50 MHz)
//   rst        : synchronous active-high reset; aborts any frame in progress
//   in_data    : byte to send
//   in_valid   : in_data is valid this cycle
//   in_ready   : FIFO has room; byte taken when in_valid && in_ready
//   tx         : serial output, idles high
//   busy       : a frame is on the line or bytes are still queued
//   byte_done  : one-cycle pulse in the last cycle of each stop bit
// Build macro UART_TX_PARITY_EN inserts an even-parity bit before STOP.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t              state;
    logic [BW-1:0]            baud_cnt;
    logic [2:0]               bit_idx;
    logic [7:0]               shift_reg;
    logic                     baud_last;

    logic [7:0]               fifo_rdata;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign in_ready  = !fifo_full;
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign fifo_pop  = (state == IDLE) && !fifo_empty;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // The head byte is captured as it leaves the FIFO; it is data, so no reset.
    always_ff @(posedge clk) begin
        if (fifo_pop) shift_reg <= fifo_rdata;
    end

    // tx and busy are registered from the state held before the edge, so the
    // line lags the FSM by one cycle: the start bit begins the cycle after the
    // pop, and the single IDLE cycle between frames stretches the stop bit by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            busy      <= (state != IDLE) || (fifo_count != '0);
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (!fifo_empty) state <= START;
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_last) begin
                        state    <= DATA;
                        bit_idx  <= '0;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    tx <= shift_reg[bit_idx];
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    // Even parity: the bit makes the total count of ones even.
                    tx <= ^shift_reg;
                    if (baud_last) begin
                        state    <= STOP;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (baud_last) begin
                        byte_done <= 1'b1;
                        state     <= IDLE;
                        baud_cnt  <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
module tb_uart_byte_tx;
    import uart_pkg::*;

    localparam int C     = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int LIMIT = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       byte_done;

    uart_byte_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx        (tx),
        .busy      (busy),
        .byte_done (byte_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: every accepted byte must come out, in order, as one
    // frame; a reset throws away everything queued or in flight.
    logic [7:0] exp_q[$];
    int epoch       = 0;
    int last_accept = 0;
    int accepts     = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            epoch++;
        end else if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            last_accept = cyc + 1;
            accepts++;
        end
    end

    int done_cnt = 0;
    int done_q[$];
    always @(negedge clk) begin
        if (byte_done === 1'b1) begin
            done_cnt++;
            done_q.push_back(cyc);
        end
    end

    // Line receiver: finds the falling edge, samples every bit in its centre.
    int         frames  = 0;
    int         ff_seen = 0;
    int         fall_q[$];
    int         s_epoch;
    logic [7:0] rx_b;
    logic       rx_start;
    logic       rx_stop;
    logic       rx_par;

    initial begin : decoder
        rx_par = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                s_epoch = epoch;
                fall_q.push_back(cyc);
                repeat (C / 2) @(negedge clk);
                rx_start = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    rx_b[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (C) @(negedge clk);
                rx_par = tx;
`endif
                repeat (C) @(negedge clk);
                rx_stop = tx;
                if (s_epoch == epoch) begin
                    frames++;
                    check("start_bit", int'(rx_start), 0);
                    check("stop_bit", int'(rx_stop), 1);
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", int'(rx_par), ($countones(rx_b) % 2));
`endif
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got byte %0d expected none", rx_b);
                    end else begin
                        check("frame_byte", int'(rx_b), int'(exp_q.pop_front()));
                    end
                    if (rx_b == 8'hFF) ff_seen++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) check("push_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(output int drop_cyc);
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < LIMIT) begin
            tick();
            n++;
        end
        drop_cyc = cyc;
        check("drain_timeout", (n < LIMIT) ? 1 : 0, 1);
    endtask

    logic [7:0] burst [5];
    int acc;
    int drop;
    int base_done;
    int base_frames;
    int base_acc;
    int n;

    initial begin
        burst[0] = CHAR_F;
        burst[1] = CHAR_I;
        burst[2] = CHAR_M;
        burst[3] = CHAR_DASH;
        burst[4] = CHAR_HASH;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("reset_tx", int'(tx), 1);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_byte_done", int'(byte_done), 0);
        rst = 1'b0;
        repeat (5) tick();

        // Single byte latency and frame timing
        fall_q.delete();
        done_q.delete();
        base_frames = frames;
        push_byte(CHAR_F);
        acc = last_accept;
        wait_drain(drop);
        check("single_frames", frames - base_frames, 1);
        check("single_fall_lat", (fall_q.size() > 0) ? fall_q[0] - acc : -1, 2);
        check("single_done_count", done_q.size(), 1);
        check("single_done_lat", (done_q.size() > 0) ? done_q[0] - acc : -1, 1 + FRAME_BITS * C);
        check("single_busy_drop", drop - acc, 2 + FRAME_BITS * C);
        repeat (3) tick();

        // Burst with in_valid held high
        fall_q.delete();
        done_q.delete();
        base_done = done_cnt;
        for (int i = 0; i < 5; i++) push_byte(burst[i]);
        check("burst_full_ready", int'(in_ready), 0);
        n = 0;
        while (!in_ready && n < LIMIT) begin
            tick();
            n++;
        end
        check("burst_ready_after_pop", (done_q.size() > 0) ? cyc - done_q[0] : -1, 1);
        wait_drain(drop);
        check("burst_done_pulses", done_cnt - base_done, 5);
        check("burst_frames", fall_q.size(), 5);
        if (fall_q.size() == 5 && done_q.size() == 5) begin
            for (int i = 1; i < 5; i++) check("burst_gap", fall_q[i] - done_q[i-1], 2);
        end
        repeat (3) tick();

        // Hold in_valid through full periods; 8'hFF only offered when full
        base_frames = frames;
        base_acc    = accepts;
        for (int i = 0; i < 80; i++) begin
            in_valid = 1'b1;
            in_data  = in_ready ? 8'($urandom_range(0, 254)) : 8'hFF;
            tick();
        end
        in_valid = 1'b0;
        wait_drain(drop);
        check("full_no_ff", ff_seen, 0);
        check("full_stream_len", frames - base_frames, accepts - base_acc);
        repeat (3) tick();

        // Random bytes with random gaps
        base_frames = frames;
        base_acc    = accepts;
        for (int i = 0; i < 16; i++) begin
            push_byte(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 20)) tick();
        end
        wait_drain(drop);
        check("rand_stream_len", frames - base_frames, accepts - base_acc);
        repeat (3) tick();

        // Reset during data bit 3 with two bytes still queued
        fall_q.delete();
        base_done   = done_cnt;
        base_frames = frames;
        push_byte(CHAR_C);
        push_byte(CHAR_S);
        push_byte(CHAR_U);
        n = 0;
        while (fall_q.size() == 0 && n < LIMIT) begin
            tick();
            n++;
        end
        check("rst_first_fall", (n < LIMIT) ? 1 : 0, 1);
        repeat (16) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_tx_high", int'(tx), 1);
        check("rst_busy_low", int'(busy), 0);
        check("rst_no_done", int'(byte_done), 0);
        check("rst_in_ready", int'(in_ready), 1);
        repeat (15 * C * 2) tick();
        check("rst_no_more_frames", fall_q.size(), 1);
        check("rst_no_done_pulses", done_cnt - base_done, 0);
        check("rst_no_decoded", frames - base_frames, 0);
        check("rst_busy_stays_low", int'(busy), 0);
        check("rst_tx_idle", int'(tx), 1);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
